mips_pc_sequencer: RTL and testbench
====================================

Name: mips_pc_sequencer

Overview:
- Owns the fetch program counter for the pipelined core and sequences PC updates: increment, hold on stall, and redirect on a resolved branch or jump from EX.
- Resolves the EX-stage PC action against its branch condition and the ALU zero status. Redirects that arrive during a stall are buffered until the stall drops.
- Drives the IF/ID squash signal and a saturating redirect counter for performance monitoring.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- CNT_WIDTH, 16, redirect counter width.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- stall  input  1  fetch/pipeline stall; PC must not advance while high.
- exValid  input  1  EX stage holds a valid instruction this cycle.
- action  input  2  PC action: 0 Inc, 1 Branch, 2 Jump, 3 JumpReg.
- condition  input  2  branch condition: 0 None, 1 EQ, 2 NE, 3 reserved (treated as None).
- zero  input  1  ALU zero status of the EX instruction.
- branchTarget  input  WIDTH  computed branch target.
- jumpTarget  input  WIDTH  jump target (J/JAL).
- regTarget  input  WIDTH  register target (JR/JALR).
- pc  output  WIDTH  current fetch PC (registered).
- flush  output  1  squash IF/ID; high exactly in cycles where a redirect is committed.
- pending  output  1  high while in state PEND.
- misaligned  output  1  one-cycle registered pulse when a committed target had nonzero bits [1:0].
- redirectCount  output  CNT_WIDTH  number of committed redirects, saturating.

Behaviour:
- Reset: while reset==0 at a rising edge:
  - pc=RESET_PC, state=RUN, pendTarget=0, misaligned=0, redirectCount=0.
  - flush is forced 0 during any cycle in which reset is low.
  - Reset overrides everything, including mid-PEND: the buffered target is discarded.
- taken resolution (combinational, only when exValid=1):
  - Inc: never taken.
  - Jump and JumpReg: always taken.
  - Branch with condition None or reserved: taken.
  - Branch with EQ: taken iff zero=1.
  - Branch with NE: taken iff zero=0.
- target selection: Branch→branchTarget, Jump→jumpTarget, JumpReg→regTarget. Bits [1:0] are forced to 0 when loaded.
- State RUN:
  - taken & !stall: pc<=target at next edge; flush=1 this cycle; redirectCount increments.
  - taken & stall: pendTarget<=target; go to PEND; flush=0; pc held.
  - !taken & !stall: pc<=pc+4, modulo 2^WIDTH (32'hFFFF_FFFC wraps to 0).
  - !taken & stall: pc held.
- State PEND:
  - exValid, action and condition are ignored (EX is frozen by the stall; a new redirect cannot displace the buffered one).
  - stall=1: hold pc and pendTarget; pending=1.
  - stall=0: pc<=pendTarget; flush=1 this cycle; redirectCount increments; go to RUN.
- Latency:
  - RUN redirect takes effect on pc one edge after the resolving cycle.
  - A buffered redirect takes effect one edge after stall deasserts.
- misaligned: registered. Set for one cycle after any committed redirect whose raw target had [1:0]!=0; 0 otherwise.
- redirectCount: saturates at all-ones and never wraps.
- flush is combinational from state/inputs and must be glitch-free at the edge; the same-cycle pc load and flush act together on IF/ID.

Test Plan:
- Reset low 2 cycles, then run with no stall and exValid=0 for 3 cycles -> pc=0,4,8,C; flush=0 throughout; redirectCount=0.
- pc=0x100, exValid=1, Branch/EQ, zero=1, branchTarget=0x200 -> flush=1 that cycle, next pc=0x200, redirectCount=1. Repeat with zero=0 -> pc=0x104, flush=0.
- Jump with jumpTarget=0x400 while stall=1 for 3 cycles -> pending=1 and pc held for 3 cycles. Change action/target during PEND -> ignored. Stall drops -> flush=1, next pc=0x400, pending=0.
- pc=0xFFFF_FFFC with no stall -> next pc=0. JumpReg with regTarget=0x1003 -> pc=0x1000, misaligned=1 for one cycle.
- Enter PEND with target 0x800, assert reset for one edge -> pc=RESET_PC, pending=0, flush=0. After release, no redirect to 0x800 occurs.
- CNT_WIDTH=2, five consecutive taken NE branches (zero=0) -> redirectCount goes 1,2,3,3,3.

Source files
------------

// File: rtl/mips_pc_sequencer_if.sv
// mips_pc_sequencer_if: EX-resolution inputs and fetch-PC outputs of the PC sequencer
interface mips_pc_sequencer_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 exValid;
    logic [1:0]           action;
    logic [1:0]           condition;
    logic                 zero;
    logic [WIDTH-1:0]     branchTarget;
    logic [WIDTH-1:0]     jumpTarget;
    logic [WIDTH-1:0]     regTarget;
    logic [WIDTH-1:0]     pc;
    logic                 flush;
    logic                 pending;
    logic                 misaligned;
    logic [CNT_WIDTH-1:0] redirectCount;

    modport master (
        output stall, exValid, action, condition, zero, branchTarget, jumpTarget, regTarget,
        input  pc, flush, pending, misaligned, redirectCount
    );

    modport slave (
        input  stall, exValid, action, condition, zero, branchTarget, jumpTarget, regTarget,
        output pc, flush, pending, misaligned, redirectCount
    );
endinterface

// File: rtl/mips_pc_sequencer.sv
// mips_pc_sequencer: fetch PC owner with increment, stall hold and buffered EX redirects
module mips_pc_sequencer #(
    parameter int             WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int             CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    mips_pc_sequencer_if.slave   bus
);
    typedef enum logic {RUN, PEND} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic                 mis_q, mis_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 taken;
    logic                 commit;
    logic [WIDTH-1:0]     target;
    logic [WIDTH-1:0]     raw;

    // Resolve the EX action: branches honour EQ/NE against zero, None/reserved always take
    always_comb begin
        taken  = bus.exValid && (bus.action != 2'd0) &&
                 !(bus.action == 2'd1 && ((bus.condition == 2'd1 && !bus.zero) ||
                                          (bus.condition == 2'd2 &&  bus.zero)));
        target = bus.action == 2'd1 ? bus.branchTarget :
                 bus.action == 2'd2 ? bus.jumpTarget : bus.regTarget;
    end

    // Next-state: the buffered target keeps its raw low bits so misalignment is reported on commit
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        raw     = '0;
        if (state_q == PEND) begin
            if (!bus.stall) begin
                commit  = 1'b1;
                raw     = pend_q;
                state_d = RUN;
            end
        end else if (taken) begin
            if (bus.stall) begin
                pend_d  = target;
                state_d = PEND;
            end else begin
                commit = 1'b1;
                raw    = target;
            end
        end else if (!bus.stall) begin
            pc_d = pc_q + WIDTH'(4);
        end
        if (commit) begin
            pc_d  = {raw[WIDTH-1:2], 2'b00};
            cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
        end
        mis_d = commit && (raw[1:0] != 2'b00);
    end

    // State register with synchronous active-low reset that also drops any buffered redirect
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.flush         = commit && reset;
    assign bus.pending       = state_q == PEND;
    assign bus.misaligned    = mis_q;
    assign bus.redirectCount = cnt_q;
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb_mips_pc_sequencer: directed plus randomized checks against a behavioural PC model
module tb_mips_pc_sequencer;
    localparam int          W   = 32;
    localparam int          CW  = 3;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_pc_sequencer_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
    mips_pc_sequencer #(.WIDTH(W), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [31:0] m_pc, m_ptgt;
    bit          m_pend, m_mis;
    int          m_cnt;
    int          vectors = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit st, input bit ev, input logic [1:0] act, input logic [1:0] cond,
                         input bit z, input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] rt);
        bus.stall        = st;
        bus.exValid      = ev;
        bus.action       = act;
        bus.condition    = cond;
        bus.zero         = z;
        bus.branchTarget = bt;
        bus.jumpTarget   = jt;
        bus.regTarget    = rt;
    endtask

    // One clock: check flush before the edge, advance the model, check registered outputs after
    task automatic step();
        bit          tk, commit, st;
        logic [31:0] tgt, raw;
        #1;
        st = bus.stall;
        tk = bus.exValid && bus.action != 2'd0 &&
             !(bus.action == 2'd1 && ((bus.condition == 2'd1 && !bus.zero) ||
                                      (bus.condition == 2'd2 && bus.zero)));
        tgt = bus.action == 2'd1 ? bus.branchTarget :
              bus.action == 2'd2 ? bus.jumpTarget : bus.regTarget;
        commit = 1'b0;
        raw = 32'h0;
        if (m_pend) begin
            if (!st) begin
                commit = 1'b1;
                raw = m_ptgt;
            end
        end else if (tk && !st) begin
            commit = 1'b1;
            raw = tgt;
        end
        chk("flush", 32'(bus.flush), 32'(rst_n && commit));
        @(posedge clk);
        if (!rst_n) begin
            m_pc = RPC;
            m_pend = 1'b0;
            m_ptgt = 32'h0;
            m_mis = 1'b0;
            m_cnt = 0;
        end else begin
            if (m_pend && !st) m_pend = 1'b0;
            else if (!m_pend && tk && st) begin
                m_pend = 1'b1;
                m_ptgt = tgt;
            end else if (!m_pend && !tk && !st) m_pc = m_pc + 32'd4;
            m_mis = commit && raw[1:0] != 2'b00;
            if (commit) begin
                m_pc = raw & ~32'd3;
                m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
            end
        end
        @(negedge clk);
        chk("pc", bus.pc, m_pc);
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
        chk("redirectCount", 32'(bus.redirectCount), 32'(m_cnt));
    endtask

    task automatic idle(input bit st);
        drive(st, 1'b0, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic jump_to(input logic [31:0] a);
        drive(1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, a, 32'h0);
        step();
    endtask

    initial begin
        m_pc = RPC; m_ptgt = 32'h0; m_pend = 1'b0; m_mis = 1'b0; m_cnt = 0;
        idle(1'b0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("tp_pc_after_3", bus.pc, 32'hC);
        chk("tp_count_zero", 32'(bus.redirectCount), 32'd0);

        jump_to(32'h100);
        drive(1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 32'h200, 32'h0, 32'h0);
        step();
        chk("tp_beq_taken", bus.pc, 32'h200);
        jump_to(32'h100);
        drive(1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 32'h200, 32'h0, 32'h0);
        step();
        chk("tp_beq_not_taken", bus.pc, 32'h104);

        drive(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, 32'h400, 32'h0);
        step(); step(); step();
        chk("tp_pend_hold", bus.pc, 32'h104);
        drive(1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 32'h0, 32'h0, 32'h999);
        step();
        idle(1'b0);
        step();
        chk("tp_pend_commit", bus.pc, 32'h400);

        jump_to(32'hFFFF_FFFC);
        idle(1'b0);
        step();
        chk("tp_wrap", bus.pc, 32'h0);
        drive(1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 32'h0, 32'h0, 32'h1003);
        step();
        chk("tp_jr_aligned", bus.pc, 32'h1000);
        chk("tp_misaligned", 32'(bus.misaligned), 32'd1);
        idle(1'b0);
        step();

        drive(1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, 32'h800, 32'h0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(1'b0);
        step();
        chk("tp_reset_drops_pend", bus.pc, RPC + 32'd4);

        for (int i = 0; i < CMAX + 2; i++) begin
            drive(1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 32'h40 * (i + 1), 32'h0, 32'h0);
            step();
        end
        chk("tp_count_saturated", 32'(bus.redirectCount), 32'(CMAX));

        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(0, 99) != 0;
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom, $urandom, $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
